// File: rtl/vga_scan_generator_if.sv
// Video bus between the scan generator, the colour mapper and the VGA DAC pins.
interface vga_scan_generator_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_en;
  logic       frame_start;
  logic [7:0] color_R;
  logic [7:0] color_G;
  logic [7:0] color_B;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    output DrawX, DrawY, pix_en, frame_start,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B,
    input  color_R, color_G, color_B
  );

  modport slave (
    input  DrawX, DrawY, pix_en, frame_start,
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B,
    output color_R, color_G, color_B
  );
endinterface

// File: rtl/vga_scan_generator.sv
// VGA raster scan: pixel divider, h/v counters, sync/blank decode and registered DAC outputs.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces colour with 8 vertical bars.
module vga_scan_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  vga_scan_generator_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BAR_W   = H_VISIBLE / 8;

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       hc_reg, hc_next;
  logic [9:0]       vc_reg, vc_next;
  logic             vga_clk_reg, vga_clk_next;
  logic             hs_reg, vs_reg, blank_n_reg;
  logic             pix_en, frame_start;
  logic             active, hs_n, vs_n;
  logic [2:0][7:0]  color_in;
  logic [2:0][7:0]  color_sel;
  logic [2:0][7:0]  rgb_out;

  always_comb begin
    pix_en       = (div_reg == DIV_W'(CLK_DIV - 1));
    div_next     = pix_en ? '0 : div_reg + 1'b1;
    vga_clk_next = (div_next >= DIV_W'(CLK_DIV / 2));
    hc_next      = hc_reg;
    vc_next      = vc_reg;
    if (pix_en) begin
      if (hc_reg == 10'(H_TOTAL - 1)) begin
        hc_next = '0;
        vc_next = (vc_reg == 10'(V_TOTAL - 1)) ? '0 : vc_reg + 10'd1;
      end else begin
        hc_next = hc_reg + 10'd1;
      end
    end
  end

  always_comb begin
    active      = (hc_reg < 10'(H_VISIBLE)) && (vc_reg < 10'(V_VISIBLE));
    hs_n        = !((hc_reg >= 10'(H_VISIBLE + H_FRONT)) &&
                    (hc_reg <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
    vs_n        = !((vc_reg >= 10'(V_VISIBLE + V_FRONT)) &&
                    (vc_reg <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
    frame_start = pix_en && (hc_reg == '0) && (vc_reg == '0);
  end

  assign color_in[0] = vga.color_R;
  assign color_in[1] = vga.color_G;
  assign color_in[2] = vga.color_B;

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] bar_full;
  logic [2:0] bar;
  // Bar index bits map straight onto channels: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
  always_comb begin
    bar_full  = hc_reg / 10'(BAR_W);
    bar       = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
    color_sel = color_in;
    if (test_mode) begin
      color_sel[0] = {8{~bar[1]}};
      color_sel[1] = {8{~bar[2]}};
      color_sel[2] = {8{~bar[0]}};
    end
  end
`else
  assign color_sel = color_in;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_reg     <= '0;
      hc_reg      <= '0;
      vc_reg      <= '0;
      vga_clk_reg <= 1'b0;
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      blank_n_reg <= 1'b0;
    end else begin
      div_reg     <= div_next;
      hc_reg      <= hc_next;
      vc_reg      <= vc_next;
      vga_clk_reg <= vga_clk_next;
      if (pix_en) begin
        hs_reg      <= hs_n;
        vs_reg      <= vs_n;
        blank_n_reg <= active;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] chan_reg;
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          chan_reg <= '0;
        end else if (pix_en) begin
          chan_reg <= active ? color_sel[gi] : 8'h00;
        end
      end
      assign rgb_out[gi] = chan_reg;
    end
  endgenerate

  assign vga.DrawX       = hc_reg;
  assign vga.DrawY       = vc_reg;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = frame_start;
  assign vga.VGA_CLK     = vga_clk_reg;
  assign vga.VGA_HS      = hs_reg;
  assign vga.VGA_VS      = vs_reg;
  assign vga.VGA_BLANK_N = blank_n_reg;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = rgb_out[0];
  assign vga.VGA_G       = rgb_out[1];
  assign vga.VGA_B       = rgb_out[2];
endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: a default-timing instance and a tiny-timing instance
// (CLK_DIV=4) checked every Clk against a reference raster model with a DAC-output queue.
module tb_vga_scan_generator;
  typedef struct packed {
    int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb; int dv;
  } cfg_t;

  localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t CFG_B = '{16, 2, 4, 2, 8, 1, 2, 1, 4};
  localparam logic [27:0] DAC_RST = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  logic Clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #10 Clk = ~Clk;

  vga_scan_generator_if ifa ();
  vga_scan_generator_if ifb ();

  // Colour mapper stand-in: a pure function of the current coordinate.
  assign ifa.color_R = ifa.DrawX[7:0];
  assign ifa.color_G = ifa.DrawY[7:0];
  assign ifa.color_B = 8'h5A;
  assign ifb.color_R = ifb.DrawX[7:0];
  assign ifb.color_G = ifb.DrawY[7:0];
  assign ifb.color_B = 8'h5A;

`ifdef VGA_TEST_PATTERN_EN
  logic tm_a = 1'b0;
  logic tm_b = 1'b0;
`endif

  vga_scan_generator #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33), .CLK_DIV(2)
  ) dut_a (
    .Clk(Clk),
    .Reset_n(rst_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_a),
`endif
    .vga(ifa)
  );

  vga_scan_generator #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(4)
  ) dut_b (
    .Clk(Clk),
    .Reset_n(rst_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm_b),
`endif
    .vga(ifb)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  bit tm = 1'b0;
  int m_div, m_hc, m_vc;
  bit last_pix;
  logic [27:0] out_exp;
  logic [27:0] sb[$];
  int cyc = 0;
  int fs_cyc, fs_count, hs_low;
  bit have_fs;

  function automatic cfg_t cfg();
    return (sel == 0) ? CFG_A : CFG_B;
  endfunction

  function automatic logic [31:0] obs_coord();
    if (sel == 0) return {12'd0, ifa.DrawX, ifa.DrawY};
    return {12'd0, ifb.DrawX, ifb.DrawY};
  endfunction

  function automatic logic [31:0] obs_strobe();
    if (sel == 0) return {29'd0, ifa.pix_en, ifa.frame_start, ifa.VGA_CLK};
    return {29'd0, ifb.pix_en, ifb.frame_start, ifb.VGA_CLK};
  endfunction

  function automatic logic [27:0] obs_dac();
    if (sel == 0)
      return {ifa.VGA_HS, ifa.VGA_VS, ifa.VGA_BLANK_N, ifa.VGA_SYNC_N, ifa.VGA_R, ifa.VGA_G, ifa.VGA_B};
    return {ifb.VGA_HS, ifb.VGA_VS, ifb.VGA_BLANK_N, ifb.VGA_SYNC_N, ifb.VGA_R, ifb.VGA_G, ifb.VGA_B};
  endfunction

  function automatic logic [27:0] dac_model(int hc, int vc);
    cfg_t c;
    bit act, hs, vs;
    logic [23:0] rgb;
    c   = cfg();
    act = (hc < c.hv) && (vc < c.vv);
    hs  = !((hc >= c.hv + c.hf) && (hc < c.hv + c.hf + c.hs));
    vs  = !((vc >= c.vv + c.vf) && (vc < c.vv + c.vf + c.vs));
    rgb = {8'(hc), 8'(vc), 8'h5A};
    if (tm) begin
      case (hc / (c.hv / 8))
        0:       rgb = 24'hFFFFFF;
        1:       rgb = 24'hFFFF00;
        2:       rgb = 24'h00FFFF;
        3:       rgb = 24'h00FF00;
        4:       rgb = 24'hFF00FF;
        5:       rgb = 24'hFF0000;
        6:       rgb = 24'h0000FF;
        default: rgb = 24'h000000;
      endcase
    end
    if (!act) rgb = 24'h0;
    return {hs, vs, act, 1'b0, rgb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One Clk step: advance the model across the rising edge, then compare at the falling edge.
  task automatic tick();
    cfg_t c;
    bit exp_pix, exp_fs, exp_vclk;
    c = cfg();
    @(negedge Clk);
    cyc++;
    if (last_pix) begin
      if (sb.size() > 0) out_exp = sb.pop_front();
      if (m_hc == c.hv + c.hf + c.hs + c.hb - 1) begin
        m_hc = 0;
        m_vc = (m_vc == c.vv + c.vf + c.vs + c.vb - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc++;
      end
    end
    m_div    = (m_div == c.dv - 1) ? 0 : m_div + 1;
    exp_pix  = (m_div == c.dv - 1);
    exp_fs   = exp_pix && (m_hc == 0) && (m_vc == 0);
    exp_vclk = (m_div >= c.dv / 2);
    check("coord", obs_coord(), {12'd0, 10'(m_hc), 10'(m_vc)});
    check("strobe", obs_strobe(), {29'd0, exp_pix, exp_fs, exp_vclk});
    check("dac", {4'd0, obs_dac()}, {4'd0, out_exp});
    if (exp_pix && obs_dac()[27] == 1'b0) hs_low++;
    if (obs_strobe()[1]) begin
      if (have_fs) check("frame_period", cyc - fs_cyc, (c.hv + c.hf + c.hs + c.hb) * (c.vv + c.vf + c.vs + c.vb) * c.dv);
      have_fs = 1'b1;
      fs_cyc  = cyc;
      fs_count++;
    end
    if (exp_pix) sb.push_back(dac_model(m_hc, m_vc));
    last_pix = exp_pix;
  endtask

  // Drop reset between edges, confirm the asynchronous clear, hold, then release on a falling edge.
  task automatic do_reset(input int s);
    sel = s;
    @(negedge Clk);
    #3;
    if (s == 0) rst_a = 1'b0; else rst_b = 1'b0;
    #1;
    check("rst_coord", obs_coord(), 32'd0);
    check("rst_strobe", obs_strobe(), 32'd0);
    check("rst_dac", {4'd0, obs_dac()}, {4'd0, DAC_RST});
    repeat (3) @(negedge Clk);
    if (s == 0) rst_a = 1'b1; else rst_b = 1'b1;
    m_div    = 0;
    m_hc     = 0;
    m_vc     = 0;
    last_pix = 1'b0;
    out_exp  = DAC_RST;
    sb.delete();
    have_fs  = 1'b0;
    fs_count = 0;
    hs_low   = 0;
  endtask

  task automatic run_until(input int hc, input int vc, input int budget);
    int n;
    n = 0;
    while (!(m_hc == hc && m_vc == vc) && n < budget) begin
      tick();
      n++;
    end
    check("reach", obs_coord(), {12'd0, 10'(hc), 10'(vc)});
  endtask

  initial begin
    do_reset(0);
    run_until(0, 2, 4000);
    check("hs_low_pixels", hs_low, 2 * CFG_A.hs);
    check("fs_count_a", fs_count, 1);
    run_until(300, 2, 1000);
    do_reset(0);
    repeat (40) tick();
    check("fs_after_reset", fs_count, 1);
`ifdef VGA_TEST_PATTERN_EN
    tm_a = 1'b1;
    tm   = 1'b1;
    do_reset(0);
    run_until(0, 1, 2000);
    tm_a = 1'b0;
    tm   = 1'b0;
`endif
    do_reset(1);
    repeat (1152 + 200) tick();
    check("fs_count_b", fs_count, 2);
    run_until(10, 5, 2000);
    do_reset(1);
    repeat (60) tick();
    check("fs_after_reset_b", fs_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
